// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a registered read port and
// full/empty flags decoded from wrap-bit extended pointers.
module sync_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] dat_i,
  input  logic             wen,
  input  logic             ren,
  output logic [WIDTH-1:0] dat_o,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             wr_acc;
  logic             rd_acc;

  // Flags come from the pointer registers only, never from wen/ren.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  // Requests are qualified against the flags as they stand before the edge.
  assign wr_acc = wen && !full;
  assign rd_acc = ren && !empty;

  // Storage array; contents are not reset, but reset blocks the write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_acc) begin
      mem[wptr[AW-1:0]] <= dat_i;
    end
  end

  // Pointer update with natural wrap through the extra MSB.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + PW'(1);
      end
      if (rd_acc) begin
        rptr <= rptr + PW'(1);
      end
    end
  end

  // Registered read port; holds its value when no read is accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dat_o <= '0;
    end else if (rd_acc) begin
      dat_o <= mem[rptr[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed vectors for sync_fifo (WIDTH=4, DEPTH=2).
module tb_sync_fifo;

  logic       clk_i;
  logic       rst_i;
  logic [3:0] dat_i;
  logic       wen;
  logic       ren;
  logic [3:0] dat_o;
  logic       full;
  logic       empty;

  int vectors;
  int miscompares;

  sync_fifo #(.WIDTH(4), .DEPTH(2)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .dat_i (dat_i),
    .wen   (wen),
    .ren   (ren),
    .dat_o (dat_o),
    .full  (full),
    .empty (empty)
  );

  // Free-running clock, 10 time-unit period.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one edge, sample 1 time unit later.
  task automatic step(input logic r, input logic w, input logic rd, input logic [3:0] d);
    rst_i = r;
    wen   = w;
    ren   = rd;
    dat_i = d;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_i = 1'b1; wen = 1'b0; ren = 1'b0; dat_i = 4'h0;
    #2;

    // Reset with concurrent wen/ren: reset wins, nothing stored.
    step(1'b1, 1'b1, 1'b1, 4'h5);
    chk("rst_empty", {3'b0, empty}, 4'h1);
    chk("rst_full",  {3'b0, full},  4'h0);
    chk("rst_dat",   dat_o,         4'h0);
    step(1'b0, 1'b0, 1'b1, 4'h0);
    chk("rst_nostore_empty", {3'b0, empty}, 4'h1);
    chk("rst_nostore_dat",   dat_o,         4'h0);

    // Fill.
    step(1'b0, 1'b1, 1'b0, 4'h3);
    chk("fill1_empty", {3'b0, empty}, 4'h0);
    chk("fill1_full",  {3'b0, full},  4'h0);
    step(1'b0, 1'b1, 1'b0, 4'h9);
    chk("fill2_full",  {3'b0, full},  4'h1);
    step(1'b0, 1'b1, 1'b0, 4'hF);
    chk("fill3_full",  {3'b0, full},  4'h1);

    // Drain.
    step(1'b0, 1'b0, 1'b1, 4'h0);
    chk("drain1_dat",  dat_o,         4'h3);
    chk("drain1_full", {3'b0, full},  4'h0);
    step(1'b0, 1'b0, 1'b1, 4'h0);
    chk("drain2_dat",   dat_o,         4'h9);
    chk("drain2_empty", {3'b0, empty}, 4'h1);
    chk("drain2_full",  {3'b0, full},  4'h0);
    step(1'b0, 1'b0, 1'b1, 4'h0);
    chk("drain3_dat",   dat_o,         4'h9);
    chk("drain3_empty", {3'b0, empty}, 4'h1);

    // Wrap-around: 8 writes each followed by a read.
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'(i));
      step(1'b0, 1'b0, 1'b1, 4'h0);
      chk("wrap_dat",   dat_o,         4'(i));
      chk("wrap_empty", {3'b0, empty}, 4'h1);
    end

    // Simultaneous read/write at full: write dropped.
    step(1'b0, 1'b1, 1'b0, 4'hB);
    step(1'b0, 1'b1, 1'b0, 4'hC);
    chk("sfull_pre_full", {3'b0, full}, 4'h1);
    step(1'b0, 1'b1, 1'b1, 4'hD);
    chk("sfull_dat",   dat_o,         4'hB);
    chk("sfull_full",  {3'b0, full},  4'h0);
    chk("sfull_empty", {3'b0, empty}, 4'h0);
    step(1'b0, 1'b0, 1'b1, 4'h0);
    chk("sfull_next_dat",   dat_o,         4'hC);
    chk("sfull_next_empty", {3'b0, empty}, 4'h1);

    // Simultaneous read/write at empty: only the write lands.
    step(1'b0, 1'b1, 1'b1, 4'h6);
    chk("sempty_dat",   dat_o,         4'hC);
    chk("sempty_empty", {3'b0, empty}, 4'h0);
    step(1'b0, 1'b0, 1'b1, 4'h0);
    chk("sempty_next_dat",   dat_o,         4'h6);
    chk("sempty_next_empty", {3'b0, empty}, 4'h1);

    // Reset mid-stream with one word stored.
    step(1'b0, 1'b1, 1'b0, 4'h7);
    chk("mid_pre_empty", {3'b0, empty}, 4'h0);
    step(1'b1, 1'b0, 1'b0, 4'h0);
    chk("mid_empty", {3'b0, empty}, 4'h1);
    chk("mid_full",  {3'b0, full},  4'h0);
    chk("mid_dat",   dat_o,         4'h0);
    step(1'b0, 1'b1, 1'b0, 4'hA);
    step(1'b0, 1'b0, 1'b1, 4'h0);
    chk("mid_after_dat",   dat_o,         4'hA);
    chk("mid_after_empty", {3'b0, empty}, 4'h1);

    wen = 1'b0; ren = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, synchronous-reset FIFO buffer of DEPTH words, each WIDTH bits wide, with full/empty status flags and a registered read port. It decouples a producer and a consumer that share one clock domain, and serves as the storage element between streaming blocks in the datapath. Writes are refused while the FIFO is full, and reads are refused while it is empty, so it can never overflow or underflow.

## Interface
- WIDTH, default 4: data word width in bits.
- DEPTH, default 2: number of storage words. Must be a power of 2 and at least 2.
- AW (localparam) = log2(DEPTH): address width.

- clk_i  input  1  single clock. All state updates on the rising edge.
- rst_i  input  1  reset, synchronous and active-high.
- dat_i  input  WIDTH  write data.
- wen  input  1  write request.
- ren  input  1  read request.
- dat_o  output  WIDTH  read data, registered.
- full  output  1  FIFO holds DEPTH words.
- empty  output  1  FIFO holds 0 words.

## Operation
- Storage is a DEPTH x WIDTH memory array. Memory contents are not reset.
- Write pointer wptr and read pointer rptr are each AW+1 bits. The extra MSB is a wrap bit.
- empty = (wptr == rptr). This is combinational from the registered pointers.
- full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]). This is also combinational.
- A write is accepted when wen && !full:
  - mem[wptr[AW-1:0]] <= dat_i
  - wptr <= wptr + 1, wrapping modulo 2^(AW+1).
- A read is accepted when ren && !empty:
  - dat_o <= mem[rptr[AW-1:0]]
  - rptr <= rptr + 1, wrapping modulo 2^(AW+1).
- A write while full is ignored. No state changes and no error flag is raised.
- A read while empty is ignored. dat_o holds its previous value.
- Simultaneous read and write:
  - Both are evaluated against the flags as they stand before the clock edge.
  - When full, only the read is accepted. The write is dropped even if ren is high.
  - When empty, only the write is accepted. dat_o is unchanged.
  - Otherwise both are accepted, and the occupancy is unchanged.
- Ordering is strict FIFO: words are read out in the exact order they were accepted.
- On reset (rst_i high at a clock edge):
  - wptr = 0, rptr = 0, dat_o = 0.
  - As a result, empty = 1 and full = 0.
  - Reset overrides any concurrent wen or ren in that cycle.

## Timing
- Write to flag latency: after the edge that accepts a write, empty deasserts (or full asserts) in the same cycle, once the new pointer value settles. There is no extra cycle of latency.
- Read latency is 1 cycle: the edge that accepts a read loads dat_o, and the value is valid immediately after that edge.
- After the first write into an empty FIFO, the earliest read acceptance is the next edge.
- Reset mid-operation:
  - Any stored words are discarded, and the FIFO reports empty after the reset edge.
  - dat_o returns to 0.
- No combinational path from dat_i to dat_o.
- Flags are decoded from the pointer registers only. There are no combinational paths from wen or ren to full or empty.

## Test plan
- Reset: assert rst_i for 1 edge while wen=1 and ren=1 → after the edge, empty=1, full=0, dat_o=0, and no word has been stored.
- Fill (WIDTH=4, DEPTH=2):
  - write 0x3, then 0x9 → empty=0 after the first edge, full=1 after the second.
  - a third write of 0xF while full is dropped, and full stays 1.
- Drain:
  - from the full state {0x3, 0x9}, read twice → dat_o=0x3, then 0x9.
  - after the second read, empty=1 and full=0.
  - a further read keeps dat_o=0x9.
- Wrap-around: stream 8 writes 0x1..0x8, each interleaved with a read → dat_o sequence 0x1..0x8 in order, with no lost or duplicated words across pointer wraps.
- Simultaneous operations:
  - at full, assert wen=1 and ren=1 → the read returns the oldest word, the write is dropped, and the count drops to 1.
  - at empty, assert wen=1 and ren=1 → the write is stored, dat_o is unchanged, and empty=0.
- Reset mid-stream: with 1 word stored, assert rst_i → empty=1, dat_o=0, and a subsequent write/read of 0xA returns 0xA.
